// File: rtl/exec_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package exec_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int DEF_W      = 32;
    localparam int DEF_UNROLL = 1;
    localparam int STEPS      = DEF_W / DEF_UNROLL;

    function automatic int calc_steps(input int w, input int unroll);
        return w / unroll;
    endfunction

endpackage

// File: rtl/exec_muldiv_step.sv
// One radix-2 iteration on the shared 2W+1 bit accumulator: shift-add for
// multiply (multiplier in the low half), restoring trial subtract for divide.
module exec_muldiv_step #(
    parameter int W = 32
) (
    input  logic           is_div,
    input  logic [W-1:0]   opnd,
    input  logic [2*W:0]   acc_in,
    output logic [2*W:0]   acc_out
);

    logic [2*W:0] shifted;
    logic [W:0]   hi;
    logic [W:0]   diff;
    logic [W:0]   sum;

    always_comb begin
        shifted = {acc_in[2*W-1:0], 1'b0};
        hi      = shifted[2*W:W];
        diff    = hi - {1'b0, opnd};
        sum     = acc_in[2*W:W] + (acc_in[0] ? {1'b0, opnd} : '0);
        acc_out = acc_in;
        if (is_div) begin
            // Remainder stays below the divisor, so the shifted high part fits in W+1 bits.
            if (hi >= {1'b0, opnd}) begin
                acc_out = {diff, shifted[W-1:1], 1'b1};
            end else begin
                acc_out = shifted;
            end
        end else begin
            acc_out = {1'b0, sum, acc_in[W-1:1]};
        end
    end

endmodule

// File: rtl/exec_muldiv_iter.sv
// Iterative multiply/divide unit: magnitude datapath with sign pre/post
// correction, UNROLL radix-2 steps per cycle, v/stall pipeline handshake.
module exec_muldiv_iter
    import exec_muldiv_pkg::*;
#(
    parameter int W      = 32,
    parameter int W_RD   = 5,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            v_i,
    input  logic [1:0]      op_i,
    input  logic            sign_i,
    input  logic [W-1:0]    opr0_i,
    input  logic [W-1:0]    opr1_i,
    input  logic            wb_i,
    input  logic [W_RD-1:0] wb_r_i,
    input  logic            stall_i,
    output logic            stall_o,
    output logic            v_o,
    output logic [W-1:0]    result_o,
    output logic            wb_o,
    output logic [W_RD-1:0] wb_r_o,
    output logic            dz_o
);

    localparam int NSTEPS = calc_steps(W, UNROLL);
    localparam int CW     = $clog2(NSTEPS + 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    op_t             op_reg;
    logic            neg_res_reg;
    logic            neg_rem_reg;
    logic            dz_reg;
    logic            wb_reg;
    logic [W_RD-1:0] wb_r_reg;
    logic [W-1:0]    opnd_reg;
    logic [2*W:0]    acc_reg;

    logic            v_o_reg;
    logic [W-1:0]    result_o_reg;
    logic            wb_o_reg;
    logic [W_RD-1:0] wb_r_o_reg;
    logic            dz_o_reg;

    logic [W-1:0]    mag0, mag1;
    logic [2*W:0]    acc_step;
    logic [W-1:0]    result_next;
    logic [2*W-1:0]  prod, prod_s;
    logic [W-1:0]    quo, rem;
    logic            unused_acc_msb;

    // Step chain: chain[0] is the registered accumulator, chain[UNROLL] the next value.
    logic [2*W:0] chain [UNROLL+1];
    assign chain[0] = acc_reg;

    generate
        for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
            exec_muldiv_step #(.W(W)) u_step (
                .is_div  (op_reg[1]),
                .opnd    (opnd_reg),
                .acc_in  (chain[gi]),
                .acc_out (chain[gi+1])
            );
        end
    endgenerate

    assign acc_step       = chain[UNROLL];
    assign unused_acc_msb = acc_step[2*W];

    always_comb begin
        mag0 = (sign_i && opr0_i[W-1]) ? -opr0_i : opr0_i;
        mag1 = (sign_i && opr1_i[W-1]) ? -opr1_i : opr1_i;
    end

    always_comb begin
        prod        = acc_step[2*W-1:0];
        prod_s      = neg_res_reg ? -prod : prod;
        quo         = acc_step[W-1:0];
        rem         = acc_step[2*W-1:W];
        result_next = '0;
        case (op_reg)
            OP_MUL:  result_next = prod_s[W-1:0];
            OP_MULH: result_next = prod_s[2*W-1:W];
            // Divide-by-zero quotient is all ones regardless of operand signs.
            OP_DIV:  result_next = dz_reg ? '1 : (neg_res_reg ? -quo : quo);
            default: result_next = neg_rem_reg ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (v_i) state_next = ST_CALC;
            ST_CALC: if (cnt_reg == CW'(1)) state_next = ST_DONE;
            ST_DONE: if (!stall_i) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg      <= '0;
            op_reg       <= OP_MUL;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            dz_reg       <= 1'b0;
            wb_reg       <= 1'b0;
            wb_r_reg     <= '0;
            opnd_reg     <= '0;
            acc_reg      <= '0;
            v_o_reg      <= 1'b0;
            result_o_reg <= '0;
            wb_o_reg     <= 1'b0;
            wb_r_o_reg   <= '0;
            dz_o_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (v_i) begin
                        cnt_reg     <= CW'(NSTEPS);
                        op_reg      <= op_t'(op_i);
                        neg_res_reg <= sign_i & (opr0_i[W-1] ^ opr1_i[W-1]);
                        neg_rem_reg <= sign_i & opr0_i[W-1];
                        dz_reg      <= op_i[1] & (opr1_i == '0);
                        wb_reg      <= wb_i;
                        wb_r_reg    <= wb_r_i;
                        // Divide iterates the dividend out of the low half; multiply the multiplier.
                        opnd_reg    <= op_i[1] ? mag1 : mag0;
                        acc_reg     <= {{(W+1){1'b0}}, (op_i[1] ? mag0 : mag1)};
                    end
                end
                ST_CALC: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        v_o_reg      <= 1'b1;
                        result_o_reg <= result_next;
                        wb_o_reg     <= wb_reg;
                        wb_r_o_reg   <= wb_r_reg;
                        dz_o_reg     <= dz_reg;
                    end
                end
                ST_DONE: begin
                    if (!stall_i) begin
                        v_o_reg  <= 1'b0;
                        wb_o_reg <= 1'b0;
                        dz_o_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_o  = (state_reg != ST_IDLE);
    assign v_o      = v_o_reg;
    assign result_o = result_o_reg;
    assign wb_o     = wb_o_reg;
    assign wb_r_o   = wb_r_o_reg;
    assign dz_o     = dz_o_reg;

endmodule
